// File: rtl/vmem_pkg.sv
// Shared types and geometry for the 640x480 video-memory write path.
// Address is {h, v}: 10-bit column above 9-bit row.
package vmem_pkg;
   localparam int unsigned H_BITS       = 10;
   localparam int unsigned V_BITS       = 9;
   localparam int unsigned ADDR_W       = H_BITS + V_BITS;
   localparam int unsigned PIX_W        = 24;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef struct packed {
      logic [H_BITS-1:0] h;
      logic [V_BITS-1:0] v;
      pixel_t            data;
   } wr_entry_t;

   localparam int unsigned ENTRY_W = $bits(wr_entry_t);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FILL  = 2'd2
   } sched_state_t;

   // True when the entry targets a visible pixel.
   function automatic logic entry_in_range(input wr_entry_t e, input int unsigned h_max,
                                           input int unsigned v_max);
      return (32'(e.h) < h_max) && (32'(e.v) < v_max);
   endfunction
endpackage

// File: rtl/vmem_wr_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of two.
// Push while full and pop while empty are ignored.
module vmem_wr_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end
endmodule

// File: rtl/vmem_wr_sched.sv
// Shares the single vmem port between scan-out (visible region) and queued
// pixel writes / full-screen fills, which only use blanking cycles.
module vmem_wr_sched
   import vmem_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [9:0]        h_addr,
   input  logic [9:0]        v_addr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [9:0]        wr_h,
   input  logic [8:0]        wr_v,
   input  logic [23:0]       wr_data,
   input  logic              fill_start,
   input  logic [23:0]       fill_color,
   output logic              fill_busy,
   output logic [18:0]       mem_addr,
   output logic              mem_we,
   output logic [23:0]       mem_wdata
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   sched_state_t      r_state;
   sched_state_t      w_next;
   logic [H_BITS-1:0] r_fh;
   logic [V_BITS-1:0] r_fv;
   pixel_t            r_fill_color;
   logic              r_fill_pending;
   logic              r_fill_busy;

   wr_entry_t         w_entry;
   wr_entry_t         w_head;
   logic [ENTRY_W-1:0] w_head_bits;
   logic [CNT_W-1:0]  w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_fill_step;
   logic              w_fill_last;
   logic              w_unused_v;

   assign w_unused_v  = v_addr[9];
   assign w_entry     = '{h: wr_h, v: wr_v, data: wr_data};
   assign w_head      = wr_entry_t'(w_head_bits);
   assign wr_ready    = rst & ~w_full & ~r_fill_pending & ~r_fill_busy;
   assign w_push      = wr_valid & wr_ready;
   assign fill_busy   = r_fill_busy;
   assign w_fill_last = (r_fh == H_BITS'(H_ACTIVE - 1)) && (r_fv == V_BITS'(V_ACTIVE - 1));

   vmem_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_entry),
      .i_pop   (w_pop),
      .o_dout  (w_head_bits),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Port mux and next state; scan-out wins whenever valid is high.
   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_fill_step = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = {h_addr, v_addr[V_BITS-1:0]};
      mem_wdata   = '0;

      if (rst && !valid) begin
         if (r_state == ST_DRAIN && !w_empty) begin
            w_pop    = 1'b1;
            mem_addr = {w_head.h, w_head.v};
            if (entry_in_range(w_head, H_ACTIVE, V_ACTIVE)) begin
               mem_we    = 1'b1;
               mem_wdata = w_head.data;
            end
         end else if (r_state == ST_FILL) begin
            w_fill_step = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = {r_fh, r_fv};
            mem_wdata   = r_fill_color;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (w_push)              w_next = ST_DRAIN;
            else if (r_fill_pending) w_next = ST_FILL;
         end
         ST_DRAIN: begin
            if (w_empty || (w_pop && !w_push && w_count == CNT_W'(1)))
               w_next = r_fill_pending ? ST_FILL : ST_IDLE;
         end
         ST_FILL: begin
            if (w_fill_step && w_fill_last) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Fill request tracking and raster counters (fh inner, fv outer).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fh           <= '0;
         r_fv           <= '0;
         r_fill_color   <= '0;
         r_fill_pending <= 1'b0;
         r_fill_busy    <= 1'b0;
      end else begin
         if (fill_start && !r_fill_busy) begin
            r_fill_pending <= 1'b1;
            r_fill_busy    <= 1'b1;
            r_fill_color   <= fill_color;
         end else if (r_state != ST_FILL && w_next == ST_FILL) begin
            r_fill_pending <= 1'b0;
         end

         if (w_fill_step) begin
            if (r_fh == H_BITS'(H_ACTIVE - 1)) begin
               r_fh <= '0;
               if (r_fv == V_BITS'(V_ACTIVE - 1)) begin
                  r_fv        <= '0;
                  r_fill_busy <= 1'b0;
               end else begin
                  r_fv <= r_fv + V_BITS'(1);
               end
            end else begin
               r_fh <= r_fh + H_BITS'(1);
            end
         end
      end
   end
endmodule
